// File: rtl/uart_fifo_ext_if.sv
// Bus bundle between the UART register block and its FIFO.
// Carries write/read requests, control strobes and the decoded status.
interface uart_fifo_ext_if #(
    parameter int DW = 8,
    parameter int AW = 4
);
    logic          flush;
    logic          err_clr;
    logic          wr;
    logic [DW-1:0] wrdata;
    logic          rd;
    logic [DW-1:0] rddata;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;

    modport master (
        output flush, err_clr, wr, wrdata, rd,
        input  rddata, empty, full, almost_full,
        input  almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, err_clr, wr, wrdata, rd,
        output rddata, empty, full, almost_full,
        output almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_ext.sv
// Parametrised UART FIFO: standard or first-word-fall-through read,
// occupancy count, watermarks, sticky error flags and flush.
module uart_fifo_ext #(
    parameter int DW        = 8,
    parameter int AW        = 4,
    parameter int AFULL_TH  = (1 << AW) - 4,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input logic            clk,
    input logic            rst,
    uart_fifo_ext_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW + 1)'(AFULL_TH);
    localparam logic [AW:0] AE_C    = (AW + 1)'(AEMPTY_TH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          ovf_q;
    logic          udf_q;
    logic          is_empty;
    logic          is_full;
    logic          rd_acc;
    logic          wr_acc;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == DEPTH_C);
    // A pop frees a slot in the same cycle, so a full FIFO still takes a write.
    assign rd_acc   = bus.rd && !is_empty;
    assign wr_acc   = bus.wr && (!is_full || rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wr_acc)
            mem[wr_ptr] <= bus.wrdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)
                cnt <= cnt + 1'b1;
            else if (rd_acc && !wr_acc)
                cnt <= cnt - 1'b1;
            ovf_q <= (bus.wr && is_full && !bus.rd) || (ovf_q && !bus.err_clr);
            udf_q <= (bus.rd && is_empty) || (udf_q && !bus.err_clr);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rddata = mem[rd_ptr];
        end else begin : g_std
            logic [DW-1:0] rd_q;
            always_ff @(posedge clk) begin
                if (rst)
                    rd_q <= '0;
                else if (!bus.flush && rd_acc)
                    rd_q <= mem[rd_ptr];
            end
            assign bus.rddata = rd_q;
        end
    endgenerate

    assign bus.count        = cnt;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = (cnt >= AF_C);
    assign bus.almost_empty = (cnt <= AE_C);
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_uart_fifo_ext.sv
// Testbench for uart_fifo_ext: standard and FWFT instances driven in
// lockstep against a queue model; read data checked by a scoreboard monitor.
module tb_uart_fifo_ext;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_fifo_ext_if #(.DW(8), .AW(4)) s ();
    uart_fifo_ext_if #(.DW(8), .AW(4)) f ();

    uart_fifo_ext #(
        .DW(8), .AW(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst), .bus(s.slave)
    );

    uart_fifo_ext #(
        .DW(8), .AW(4), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)
    ) u_fw (
        .clk(clk), .rst(rst), .bus(f.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic       rd_fire = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: standard-mode read data lands one edge after a pop.
    always begin
        logic fire;
        @(posedge clk);
        fire = rd_fire;
        @(negedge clk);
        if (fire) begin
            if (exp_q.size() == 0) begin
                chk("sb_underrun", 1, 0);
            end else begin
                chk("rddata", {24'd0, s.rddata}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle_inputs();
        s.wr = 0; s.rd = 0; s.wrdata = 0; s.flush = 0; s.err_clr = 0;
        f.wr = 0; f.rd = 0; f.wrdata = 0; f.flush = 0; f.err_clr = 0;
    endtask

    task automatic check_status();
        int n;
        n = mq.size();
        chk("count", {27'd0, s.count}, n);
        chk("empty", {31'd0, s.empty}, (n == 0) ? 1 : 0);
        chk("full", {31'd0, s.full}, (n == 16) ? 1 : 0);
        chk("almost_full", {31'd0, s.almost_full}, (n >= 12) ? 1 : 0);
        chk("almost_empty", {31'd0, s.almost_empty}, (n <= 2) ? 1 : 0);
        chk("overflow", {31'd0, s.overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, s.underflow}, {31'd0, m_udf});
        chk("f_count", {27'd0, f.count}, n);
        chk("f_empty", {31'd0, f.empty}, (n == 0) ? 1 : 0);
        if (n != 0)
            chk("f_head", {24'd0, f.rddata}, {24'd0, mq[0]});
    endtask

    task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                       input logic fl = 1'b0, input logic ec = 1'b0);
        bit ra;
        bit wa;
        ra = 0;
        s.wr = w; s.wrdata = d; s.rd = r; s.flush = fl; s.err_clr = ec;
        f.wr = w; f.wrdata = d; f.rd = r; f.flush = fl; f.err_clr = ec;
        if (fl) begin
            mq.delete();
        end else begin
            ra = r && (mq.size() != 0);
            wa = w && ((mq.size() != 16) || ra);
            m_ovf = (w && mq.size() == 16 && !r) || (m_ovf && !ec);
            m_udf = (r && mq.size() == 0) || (m_udf && !ec);
            if (ra) exp_q.push_back(mq.pop_front());
            if (wa) mq.push_back(d);
        end
        rd_fire = ra;
        @(posedge clk);
        #1;
        rd_fire = 0;
        idle_inputs();
        check_status();
    endtask

    task automatic do_reset(input logic w);
        rst = 1;
        s.wr = w; s.wrdata = 8'h77; s.rd = w;
        f.wr = w; f.wrdata = 8'h77; f.rd = w;
        mq.delete();
        m_ovf = 0;
        m_udf = 0;
        rd_fire = 0;
        @(posedge clk);
        #1;
        rst = 0;
        idle_inputs();
        check_status();
        chk("rst_rddata", {24'd0, s.rddata}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset(1'b0);

        for (int i = 1; i <= 16; i++)
            cyc(1, 8'(i), 0);
        chk("full_after_16", {31'd0, s.full}, 1);
        cyc(1, 8'h11, 0);
        chk("ovf_set", {31'd0, s.overflow}, 1);
        for (int i = 0; i < 16; i++)
            cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0, 0, 1);
        chk("ovf_clr", {31'd0, s.overflow}, 0);

        cyc(1, 8'hA5, 1);
        chk("udf_set", {31'd0, s.underflow}, 1);
        chk("udf_count", {27'd0, s.count}, 1);
        cyc(0, 8'h00, 1);
        cyc(0, 8'h00, 0, 0, 1);

        for (int i = 0; i < 16; i++)
            cyc(1, 8'(8'h20 + i), 0);
        for (int i = 0; i < 20; i++)
            cyc(1, 8'(8'h40 + i), 1);
        chk("stream_no_ovf", {31'd0, s.overflow}, 0);
        for (int i = 0; i < 16; i++)
            cyc(0, 8'h00, 1);

        cyc(1, 8'h3C, 0);
        chk("fwft_visible", {24'd0, f.rddata}, 8'h3C);
        chk("fwft_not_empty", {31'd0, f.empty}, 0);
        cyc(0, 8'h00, 1);
        chk("fwft_empty_after_pop", {31'd0, f.empty}, 1);

        cyc(0, 8'h00, 1, 0, 1);
        chk("set_wins_clr", {31'd0, s.underflow}, 1);
        for (int i = 0; i < 9; i++)
            cyc(1, 8'(8'h60 + i), 0);
        cyc(1, 8'hEE, 0, 1, 0);
        chk("flush_count", {27'd0, s.count}, 0);
        chk("flush_keeps_udf", {31'd0, s.underflow}, 1);
        cyc(1, 8'h81, 0);
        cyc(0, 8'h00, 1);

        for (int i = 0; i < 5; i++)
            cyc(1, 8'(8'h90 + i), 0);
        do_reset(1'b1);
        cyc(0, 8'h00, 0);

        @(posedge clk);
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
